fpga_ccff_loader: RTL and testbench

Configuration-chain loader for the parametrised fabric generation: accepts a configuration bitstream as DATA_W-bit words over a valid/ready stream and serialises it into NUM_CHAINS parallel ccff chains of CHAIN_LEN bits each. It drives each chain's ccff_head and a shift enable that gates prog_clk to the fabric configuration flops. An optional verify pass re-streams the same bitstream and compares each ccff_tail against the bit being shifted in, flagging the first mismatch. It sits between the host/SPI bitstream source and fpga_top's ccff_head/ccff_tail ports.

---
 rtl/fpga_ccff_loader.sv | 133 +++++++++++++
 tb/tb_fpga_ccff_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_ccff_loader.sv
// rtl/fpga_ccff_loader.sv - serialises a word stream into parallel ccff chains, with optional tail verify
module fpga_ccff_loader #(
    parameter int NUM_CHAINS = 1,
    parameter int CHAIN_LEN  = 64,
    parameter int DATA_W     = 8
) (
    input  logic                         prog_clk,
    input  logic                         pReset,
    input  logic                         start,
    input  logic                         verify,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [NUM_CHAINS-1:0]        ccff_head,
    input  logic [NUM_CHAINS-1:0]        ccff_tail,
    output logic                         cfg_shift_en,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [$clog2(CHAIN_LEN)-1:0] err_idx
);

    localparam int SPW   = DATA_W / NUM_CHAINS;
    localparam int IDX_W = $clog2(CHAIN_LEN);
    localparam int SUB_W = (SPW > 1) ? $clog2(SPW) : 1;

    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(CHAIN_LEN - 1);
    localparam logic [SUB_W-1:0] LAST_SUB = SUB_W'(SPW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0]     data_buf;
    logic [SUB_W-1:0]      sub_q;
    logic [IDX_W-1:0]      bit_cnt;
    logic                  mode_q;
    logic [NUM_CHAINS-1:0] slice;
    logic                  mismatch;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        cfg_shift_en = 1'b0;
        done         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                cfg_shift_en = 1'b1;
                // The final word goes straight to DONE so no trailing word is requested.
                if (bit_cnt == LAST_BIT) begin
                    state_d = DONE;
                end else if (sub_q == LAST_SUB) begin
                    state_d = FETCH;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign slice     = data_buf[int'(sub_q) * NUM_CHAINS +: NUM_CHAINS];
    assign ccff_head = cfg_shift_en ? slice : '0;
    assign mismatch  = mode_q && cfg_shift_en && (|(ccff_tail ^ ccff_head));

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            data_buf <= '0;
            sub_q    <= '0;
            bit_cnt  <= '0;
            mode_q   <= 1'b0;
            err      <= 1'b0;
            err_idx  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q  <= verify;
                        bit_cnt <= '0;
                        sub_q   <= '0;
                        err     <= 1'b0;
                        err_idx <= '0;
                    end
                end
                FETCH: begin
                    if (in_valid) begin
                        data_buf <= in_data;
                        sub_q    <= '0;
                    end
                end
                SHIFT: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    sub_q   <= (sub_q == LAST_SUB) ? '0 : sub_q + 1'b1;
                    // Only the first mismatch of a pass is recorded.
                    if (mismatch && !err) begin
                        err     <= 1'b1;
                        err_idx <= bit_cnt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_ccff_loader.sv
// tb/tb_fpga_ccff_loader.sv - bench for fpga_ccff_loader against a chain model and stream reference
module tb_fpga_ccff_loader;

    localparam int NC    = 2;
    localparam int L     = 8;
    localparam int DW    = 4;
    localparam int SPW   = DW / NC;
    localparam int WORDS = L / SPW;
    localparam int IW    = $clog2(L);

    logic          clk = 1'b0;
    logic          pReset;
    logic          start;
    logic          verify;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [NC-1:0] ccff_head;
    logic [NC-1:0] ccff_tail;
    logic          cfg_shift_en;
    logic          busy;
    logic          done;
    logic          err;
    logic [IW-1:0] err_idx;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] stream   [WORDS];
    logic [NC-1:0] loaded   [L];
    logic [NC-1:0] obs_head [L];
    logic [NC-1:0] dir_seq  [L];
    logic [IW-1:0] last_idx;
    logic [L-1:0]  chain    [NC];

    always #5 clk = ~clk;

    fpga_ccff_loader #(.NUM_CHAINS(NC), .CHAIN_LEN(L), .DATA_W(DW)) dut (
        .prog_clk     (clk),
        .pReset       (pReset),
        .start        (start),
        .verify       (verify),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ccff_head    (ccff_head),
        .ccff_tail    (ccff_tail),
        .cfg_shift_en (cfg_shift_en),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .err_idx      (err_idx)
    );

    // Fabric chains: each shifts its head bit in whenever the loader enables shifting.
    always @(posedge clk) begin
        if (cfg_shift_en) begin
            for (int c = 0; c < NC; c++) begin
                chain[c] <= {chain[c][L-2:0], ccff_head[c]};
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NC; c++) begin
            ccff_tail[c] = chain[c][L-1];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit entering chain c at shift k: word k/SPW, LSB-first, chain c takes every NC-th bit.
    function automatic logic [NC-1:0] exp_head(input int k);
        logic [NC-1:0] r;
        logic [DW-1:0] w;
        w = stream[k / SPW];
        for (int c = 0; c < NC; c++) begin
            r[c] = (w >> ((k % SPW) * NC + c)) & 1'b1;
        end
        return r;
    endfunction

    task automatic flip(input int k, input int c);
        stream[k / SPW] = stream[k / SPW] ^ DW'(1 << ((k % SPW) * NC + c));
    endtask

    task automatic run_pass(input bit vmode, input int stall, input bit noise, input int rst_at);
        int   shifts, hs, dones, done_at, stall_left, head_bad, fetch_shift, busy_bad;
        logic exp_err;
        int   exp_idx;
        logic err_d;
        logic [IW-1:0] idx_d;
        exp_err = 1'b0;
        exp_idx = 0;
        if (vmode) begin
            for (int k = 0; k < L; k++) begin
                if (!exp_err && exp_head(k) !== loaded[k]) begin
                    exp_err = 1'b1;
                    exp_idx = k;
                end
            end
        end
        shifts = 0; hs = 0; dones = 0; done_at = 0; head_bad = 0;
        fetch_shift = 0; busy_bad = 0; stall_left = stall;
        err_d = 1'b0; idx_d = '0;
        start = 1'b1; verify = vmode; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; verify = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            if (cfg_shift_en) begin
                if (shifts < L) begin
                    obs_head[shifts] = ccff_head;
                    if (ccff_head !== exp_head(shifts)) head_bad++;
                end
                if (in_ready) fetch_shift++;
                shifts++;
                if (rst_at > 0 && shifts == rst_at) begin
                    chk("err_before_reset", 32'(err), 32'(exp_err && exp_idx < rst_at - 1));
                    pReset = 1'b1; in_valid = 1'b0; start = 1'b0;
                    @(negedge clk);
                    pReset = 1'b0;
                    chk("reset_outputs", {in_ready, ccff_head, cfg_shift_en, busy, done, err, err_idx}, 32'd0);
                    return;
                end
            end
            if (!busy && dones == 0) busy_bad++;
            if (done) begin
                dones++;
                done_at = n;
                err_d = err;
                idx_d = err_idx;
            end
            if (dones > 0 && n > done_at) begin
                chk("busy_after_done", 32'(busy), 32'd0);
                chk("err_held", 32'(err), 32'(exp_err));
                break;
            end
            start = noise && cfg_shift_en;
            if (in_ready) begin
                if (stall_left > 0) begin
                    in_valid = 1'b0;
                    stall_left--;
                end else begin
                    in_valid = 1'b1;
                    in_data = (hs < WORDS) ? stream[hs] : DW'($urandom);
                    hs++;
                    stall_left = stall;
                end
            end else begin
                in_valid = noise;
                in_data = DW'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0;
        chk("done_pulses", 32'(dones), 32'd1);
        chk("shift_cycles", 32'(shifts), 32'(L));
        chk("handshakes", 32'(hs), 32'(WORDS));
        chk("head_mismatches", 32'(head_bad), 32'd0);
        chk("shift_in_fetch", 32'(fetch_shift), 32'd0);
        chk("busy_gaps", 32'(busy_bad), 32'd0);
        chk("done_cycle", 32'(done_at + 1), 32'(2 + WORDS * (SPW + 1) + WORDS * stall));
        chk("err_at_done", 32'(err_d), 32'(exp_err));
        chk("err_idx_at_done", 32'(idx_d), 32'(exp_idx));
        last_idx = idx_d;
        for (int k = 0; k < L; k++) loaded[k] = exp_head(k);
    endtask

    initial begin
        pReset = 1'b1; start = 1'b0; verify = 1'b0; in_valid = 1'b0; in_data = '0;
        dir_seq[0] = 2'b01; dir_seq[1] = 2'b00; dir_seq[2] = 2'b10; dir_seq[3] = 2'b00;
        dir_seq[4] = 2'b11; dir_seq[5] = 2'b00; dir_seq[6] = 2'b00; dir_seq[7] = 2'b01;
        repeat (3) @(negedge clk);
        chk("reset_state", {in_ready, ccff_head, cfg_shift_en, busy, done, err, err_idx}, 32'd0);
        pReset = 1'b0;
        @(negedge clk);

        stream[0] = 4'h1; stream[1] = 4'h2; stream[2] = 4'h3; stream[3] = 4'h4;
        run_pass(1'b0, 0, 1'b0, 0);
        for (int k = 0; k < L; k++) chk($sformatf("dir_head_%0d", k), 32'(obs_head[k]), 32'(dir_seq[k]));

        run_pass(1'b1, 0, 1'b0, 0);

        flip(4, 1);
        flip(6, 0);
        run_pass(1'b1, 0, 1'b0, 0);
        chk("dir_err_idx", 32'(last_idx), 32'd4);

        for (int w = 0; w < WORDS; w++) stream[w] = DW'($urandom);
        run_pass(1'b0, 3, 1'b0, 0);

        for (int w = 0; w < WORDS; w++) stream[w] = DW'($urandom);
        run_pass(1'b0, 0, 1'b1, 0);

        flip(1, 0);
        run_pass(1'b1, 0, 1'b0, 3);
        @(negedge clk);
        for (int w = 0; w < WORDS; w++) stream[w] = DW'($urandom);
        run_pass(1'b0, 0, 1'b0, 0);

        for (int it = 0; it < 6; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                for (int w = 0; w < WORDS; w++) stream[w] = DW'($urandom);
                run_pass(1'b0, $urandom_range(0, 2), 1'(it & 1), 0);
            end else begin
                if ($urandom_range(0, 1) == 1) flip($urandom_range(0, L - 1), $urandom_range(0, NC - 1));
                run_pass(1'b1, $urandom_range(0, 2), 1'(it & 1), 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
